// File: rtl/datapath_bus.sv
// datapath_bus: Mini-SRC shared datapath bus with 16 GPRs, HI and LO registers,
// and a 24-source priority multiplexer driving BusMuxOut.
// Optional feature macro: DATAPATH_R0_ZERO_EN (R0 hardwired to zero).
module datapath_bus #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic [15:0]                Rin,
  input  logic                       HIin,
  input  logic                       LOin,
  input  logic [15:0]                Rout,
  input  logic                       HIout,
  input  logic                       LOout,
  input  logic                       Zhighout,
  input  logic                       Zlowout,
  input  logic                       PCout,
  input  logic                       MDRout,
  input  logic                       In_Portout,
  input  logic                       Cout,
  input  logic [DATA_WIDTH-1:0]      BusMuxIn_Zhigh,
  input  logic [DATA_WIDTH-1:0]      BusMuxIn_Zlow,
  input  logic [DATA_WIDTH-1:0]      BusMuxIn_PC,
  input  logic [DATA_WIDTH-1:0]      BusMuxIn_MDR,
  input  logic [DATA_WIDTH-1:0]      BusMuxIn_In_Port,
  input  logic [DATA_WIDTH-1:0]      C_sign_extended,
  output logic [DATA_WIDTH-1:0]      BusMuxOut,
  output logic [18*DATA_WIDTH-1:0]   regs_q,
  output logic                       bus_conflict
);

  localparam int unsigned NUM_REGS = 18;
  localparam int unsigned NUM_SRCS = 24;

  logic [NUM_SRCS-1:0]        sel;
  logic [NUM_REGS-1:0]        load_en;
  logic [DATA_WIDTH-1:0]      src [NUM_SRCS];
  logic [18*DATA_WIDTH-1:0]   regs_d;
  logic [18*DATA_WIDTH-1:0]   regs_rst;
  logic                       found;

  // Gather bus sources indexed by their source code
  always_comb begin
    sel     = {Cout, In_Portout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout, Rout};
    load_en = {LOin, HIin, Rin};
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      src[i] = regs_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
    src[18] = BusMuxIn_Zhigh;
    src[19] = BusMuxIn_Zlow;
    src[20] = BusMuxIn_PC;
    src[21] = BusMuxIn_MDR;
    src[22] = BusMuxIn_In_Port;
    src[23] = C_sign_extended;
`ifdef DATAPATH_R0_ZERO_EN
    src[0]  = '0;
`endif
  end

  // Priority encode: lowest asserted source code drives the bus
  always_comb begin
    BusMuxOut = '0;
    found     = 1'b0;
    for (int unsigned k = 0; k < NUM_SRCS; k++) begin
      if (sel[k] && !found) begin
        BusMuxOut = src[k];
        found     = 1'b1;
      end
    end
    // Clearing the lowest set bit leaves something only if two or more were set
    bus_conflict = |(sel & (sel - NUM_SRCS'(1)));
  end

  // Next register contents: enabled registers capture the current bus value
  always_comb begin
    regs_d = regs_q;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (load_en[i]) begin
        regs_d[i*DATA_WIDTH +: DATA_WIDTH] = BusMuxOut;
      end
    end
    regs_rst = {NUM_REGS{RESET_VALUE}};
`ifdef DATAPATH_R0_ZERO_EN
    regs_d[DATA_WIDTH-1:0]   = '0;
    regs_rst[DATA_WIDTH-1:0] = '0;
`endif
  end

  // Register file update; clear overrides every load enable
  always_ff @(posedge clock) begin
    if (clear) begin
      regs_q <= regs_rst;
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: tb/tb_datapath_bus.sv
// tb_datapath_bus: directed stimulus with a scoreboard queue and a separate
// monitor that compares bus, conflict flag and register contents each cycle.
module tb_datapath_bus;

  localparam int unsigned W = 32;

`ifdef DATAPATH_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              clr;
  logic [23:0]       osel;
  logic [17:0]       isel;
  logic [W-1:0]      c_val;
  logic [W-1:0]      bus;
  logic [18*W-1:0]   regs;
  logic              conf;

  always #5 clk = ~clk;

  datapath_bus #(.DATA_WIDTH(W), .RESET_VALUE('0)) dut (
    .clock            (clk),
    .clear            (clr),
    .Rin              (isel[15:0]),
    .HIin             (isel[16]),
    .LOin             (isel[17]),
    .Rout             (osel[15:0]),
    .HIout            (osel[16]),
    .LOout            (osel[17]),
    .Zhighout         (osel[18]),
    .Zlowout          (osel[19]),
    .PCout            (osel[20]),
    .MDRout           (osel[21]),
    .In_Portout       (osel[22]),
    .Cout             (osel[23]),
    .BusMuxIn_Zhigh   (32'hAAAA_0001),
    .BusMuxIn_Zlow    (32'h5555_0002),
    .BusMuxIn_PC      (32'h0000_0010),
    .BusMuxIn_MDR     (32'hCAFE_F00D),
    .BusMuxIn_In_Port (32'h0BAD_0BAD),
    .C_sign_extended  (c_val),
    .BusMuxOut        (bus),
    .regs_q           (regs),
    .bus_conflict     (conf)
  );

  typedef struct {
    int          id;
    logic [W-1:0] bus;
    logic        conf;
    logic        chk_regs;
    logic [18*W-1:0] regs;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] model [18];
  logic         model_valid;
  logic         stim_done;
  int           step_id;

  // Drive one vector just after a rising edge, queue its expectation, then
  // advance the register model to what the next edge should produce.
  task automatic apply(input logic [23:0] os, input logic [17:0] is, input logic cl,
                       input logic [W-1:0] cv, input logic [W-1:0] ebus, input logic econf);
    exp_t e;
    @(posedge clk);
    #1;
    osel  = os;
    isel  = is;
    clr   = cl;
    c_val = cv;
    e.id       = step_id;
    e.bus      = ebus;
    e.conf     = econf;
    e.chk_regs = model_valid;
    for (int i = 0; i < 18; i++) e.regs[i*W +: W] = model[i];
    sb.push_back(e);
    step_id++;
    if (cl) begin
      for (int i = 0; i < 18; i++) model[i] = '0;
      model_valid = 1'b1;
    end else begin
      for (int i = 0; i < 18; i++) if (is[i]) model[i] = ebus;
      if (R0Z) model[0] = '0;
    end
  endtask

  function automatic logic [23:0] o(input int unsigned code);
    logic [23:0] v;
    v = '0;
    v[code] = 1'b1;
    return v;
  endfunction

  function automatic logic [17:0] ld(input int unsigned code);
    logic [17:0] v;
    v = '0;
    v[code] = 1'b1;
    return v;
  endfunction

  // Stimulus
  initial begin
    logic [W-1:0] r0v;
    logic [W-1:0] r0f;
    stim_done   = 1'b0;
    model_valid = 1'b0;
    step_id     = 0;
    osel = '0; isel = '0; clr = 1'b1; c_val = '0;
    for (int i = 0; i < 18; i++) model[i] = 'x;
    r0v = R0Z ? 32'h0 : 32'hDEAD_BEEF;
    r0f = R0Z ? 32'h0 : 32'hFFFF_FFFF;

    apply('0, '0, 1'b1, '0, 32'h0, 1'b0);                              // clear edge 1
    apply('0, '0, 1'b1, '0, 32'h0, 1'b0);                              // clear edge 2
    apply('0, '0, 1'b0, '0, 32'h0, 1'b0);                              // idle, regs all zero
    apply(o(23), ld(0), 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);     // C -> R0
    apply(o(0), ld(1), 1'b0, '0, r0v, 1'b0);                           // R0 -> R1
    apply(o(1) | o(20), '0, 1'b0, '0, r0v, 1'b1);                      // R1 beats PC
    apply(o(23), ld(16) | ld(17), 1'b1, 32'h1234, 32'h1234, 1'b0);     // clear beats loads
    apply(o(21), ld(2), 1'b0, '0, 32'hCAFE_F00D, 1'b0);                // MDR -> R2
    apply(o(2), ld(2) | ld(16), 1'b0, '0, 32'hCAFE_F00D, 1'b0);        // R2 self-load + HI
    apply(o(16) | o(17) | o(18), ld(17), 1'b0, '0, 32'hCAFE_F00D, 1'b1); // HI wins -> LO
    apply(o(19), ld(15), 1'b0, '0, 32'h5555_0002, 1'b0);               // Zlow -> R15
    apply(o(22) | o(23), ld(3), 1'b0, 32'h1234, 32'h0BAD_0BAD, 1'b1);  // In_Port beats C
    apply(o(15), '0, 1'b0, '0, 32'h5555_0002, 1'b0);                   // read R15
    apply(o(17), '0, 1'b0, '0, 32'hCAFE_F00D, 1'b0);                   // read LO
    apply(o(18), ld(4), 1'b0, '0, 32'hAAAA_0001, 1'b0);                // Zhigh -> R4
    apply(o(20) | o(3), '0, 1'b0, '0, 32'h0BAD_0BAD, 1'b1);            // R3 beats PC
    apply('0, '0, 1'b0, '0, 32'h0, 1'b0);                              // no select
    apply(o(23), ld(0), 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);     // all-ones -> R0
    apply(o(0), '0, 1'b0, '0, r0f, 1'b0);                              // read R0
    apply('0, '0, 1'b0, '0, 32'h0, 1'b0);                              // final state
    @(posedge clk);
    #1;
    osel = '0; isel = '0; clr = 1'b0;
    stim_done = 1'b1;
  end

  // Monitor: compare every queued expectation on the falling edge
  initial begin
    int checks;
    int errors;
    int cycles;
    int idle;
    exp_t e;
    checks = 0; errors = 0; cycles = 0; idle = 0;
    forever begin
      @(negedge clk);
      cycles++;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus !== e.bus) begin
          errors++;
          $display("FAIL bus step %0d: got %h expected %h", e.id, bus, e.bus);
        end
        checks++;
        if (conf !== e.conf) begin
          errors++;
          $display("FAIL bus_conflict step %0d: got %b expected %b", e.id, conf, e.conf);
        end
        if (e.chk_regs) begin
          checks++;
          if (regs !== e.regs) begin
            errors++;
            $display("FAIL regs_q step %0d: got %h expected %h", e.id, regs, e.regs);
          end
        end
      end
      if (stim_done) idle++;
      if (stim_done && idle > 2) begin
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
      if (cycles > 1000) begin
        errors++;
        $display("FAIL timeout: got %0d cycles expected at most 1000", cycles);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

endmodule
